// File: rtl/load_store_queue.sv
// In-order load/store queue for the Tomasulo core: snoops the CDB for operands,
// accesses a private word-addressed data memory and broadcasts load results as CDB requester.
module load_store_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MEM_LAT    = 2,
  parameter logic [3:0]  LABEL_BASE = 4'd12,
  parameter int unsigned MEM_WORDS  = 64
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        WEN,
  input  logic        opIn,
  input  logic [31:0] baseData,
  input  logic [3:0]  baseLabel,
  input  logic [31:0] storeData,
  input  logic [3:0]  storeLabel,
  input  logic [31:0] offset,
  output logic        isFull,
  output logic [3:0]  writeable_labelOut,
  input  logic        BCEN,
  input  logic [3:0]  BClabel,
  input  logic [31:0] BCdata,
  output logic        require,
  input  logic        requireAC,
  output logic [31:0] dataOut,
  output logic [3:0]  labelOut
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, REQ} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic          valid    [DEPTH];
  logic          is_store [DEPTH];
  logic [31:0]   vj       [DEPTH];
  logic [31:0]   vk       [DEPTH];
  logic [31:0]   offs     [DEPTH];
  logic [3:0]    qj       [DEPTH];
  logic [3:0]    qk       [DEPTH];

  logic [31:0]   mem [MEM_WORDS];

  logic [IW-1:0] head, tail;
  logic [IW:0]   count, count_next;

  logic          head_ready, access_done, retire, enq;
  logic [31:0]   eff;
  logic [AW-1:0] addr;
  logic [3:0]    head_tag;
  logic [3:0]    enq_qj, enq_qk;
  logic [31:0]   enq_vj, enq_vk;
  logic          unused_eff;

  assign head_ready  = valid[head] && (qj[head] == '0) && (!is_store[head] || (qk[head] == '0));
  assign eff         = vj[head] + offs[head];
  assign addr        = eff[AW+1:2];
  assign unused_eff  = ^{eff[31:AW+2], eff[1:0]};
  assign head_tag    = LABEL_BASE + 4'(head);
  assign access_done = (state == ACCESS) && (cnt == '0);
  assign retire      = (access_done && is_store[head]) || ((state == REQ) && requireAC);
  // A full queue may still accept when the head retires on the same edge.
  assign enq         = WEN && ((count < (IW+1)'(DEPTH)) || retire);

  assign writeable_labelOut = LABEL_BASE + 4'(tail);

  // Operands broadcast on the issue edge are captured directly.
  always_comb begin
    enq_qj = baseLabel;
    enq_vj = baseData;
    enq_qk = storeLabel;
    enq_vk = storeData;
    if (BCEN && (baseLabel != '0) && (baseLabel == BClabel)) begin
      enq_qj = '0;
      enq_vj = BCdata;
    end
    if (BCEN && (storeLabel != '0) && (storeLabel == BClabel)) begin
      enq_qk = '0;
      enq_vk = BCdata;
    end
  end

  always_comb begin
    count_next = count;
    if (enq && !retire)
      count_next = count + (IW+1)'(1);
    else if (!enq && retire)
      count_next = count - (IW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        valid[i] <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      isFull   <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      require  <= 1'b0;
      dataOut  <= '0;
      labelOut <= '0;
    end else begin
      if (BCEN) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (valid[i] && (qj[i] != '0) && (qj[i] == BClabel)) begin
            vj[i] <= BCdata;
            qj[i] <= '0;
          end
          if (valid[i] && (qk[i] != '0) && (qk[i] == BClabel)) begin
            vk[i] <= BCdata;
            qk[i] <= '0;
          end
        end
      end

      case (state)
        IDLE: begin
          if (head_ready) begin
            state <= ACCESS;
            cnt   <= CW'(MEM_LAT - 1);
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (is_store[head]) begin
            state <= IDLE;
          end else begin
            dataOut  <= mem[addr];
            labelOut <= head_tag;
            require  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (requireAC) begin
            require  <= 1'b0;
            dataOut  <= '0;
            labelOut <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (retire) begin
        valid[head] <= 1'b0;
        head        <= head + IW'(1);
      end

      // Placed after retire so a same-slot refill on a full queue wins.
      if (enq) begin
        valid[tail]    <= 1'b1;
        is_store[tail] <= opIn;
        vj[tail]       <= enq_vj;
        qj[tail]       <= enq_qj;
        vk[tail]       <= enq_vk;
        qk[tail]       <= enq_qk;
        offs[tail]     <= offset;
        tail           <= tail + IW'(1);
      end

      count  <= count_next;
      isFull <= (count_next == (IW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (nRST && access_done && is_store[head])
      mem[addr] <= vk[head];
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed vector bench for load_store_queue: one record per clock cycle,
// followed by hand sequences for reset aborting a pending request and a store access.
module tb_load_store_queue;

  logic        clk = 1'b0;
  logic        nRST, WEN, opIn, BCEN, requireAC;
  logic [31:0] baseData, storeData, offset, BCdata;
  logic [3:0]  baseLabel, storeLabel, BClabel;
  logic        isFull, require;
  logic [3:0]  writeable_labelOut, labelOut;
  logic [31:0] dataOut;

  int n_vec = 0;
  int n_mis = 0;

  localparam logic LD = 1'b0;
  localparam logic ST = 1'b1;

  load_store_queue #(.DEPTH(4), .MEM_LAT(2), .LABEL_BASE(4'd12), .MEM_WORDS(64)) dut (
    .clk(clk), .nRST(nRST), .WEN(WEN), .opIn(opIn),
    .baseData(baseData), .baseLabel(baseLabel),
    .storeData(storeData), .storeLabel(storeLabel), .offset(offset),
    .isFull(isFull), .writeable_labelOut(writeable_labelOut),
    .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
    .require(require), .requireAC(requireAC),
    .dataOut(dataOut), .labelOut(labelOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n, wen, op;
    logic [31:0] base;
    logic [3:0]  bl;
    logic [31:0] sd;
    logic [3:0]  sl;
    logic [31:0] off;
    logic        bcen;
    logic [3:0]  bcl;
    logic [31:0] bcd;
    logic        ac;
  } in_t;

  typedef struct packed {
    logic        full;
    logic [3:0]  wl;
    logic        req;
    logic [31:0] d;
    logic [3:0]  l;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  function automatic out_t E(logic f, logic [3:0] wl, logic r, logic [31:0] d, logic [3:0] l);
    out_t e;
    e.full = f; e.wl = wl; e.req = r; e.d = d; e.l = l;
    return e;
  endfunction

  function automatic vec_t nop(logic ac, out_t e);
    vec_t v;
    v = '0;
    v.i.rst_n = 1'b1;
    v.i.ac    = ac;
    v.o       = e;
    return v;
  endfunction

  function automatic vec_t rst(out_t e);
    vec_t v;
    v = '0;
    v.o = e;
    return v;
  endfunction

  function automatic vec_t iss(logic op, logic [31:0] base, logic [3:0] bl, logic [31:0] sd,
                               logic [3:0] sl, logic [31:0] off, out_t e);
    vec_t v;
    v = nop(1'b0, e);
    v.i.wen = 1'b1; v.i.op = op; v.i.base = base; v.i.bl = bl;
    v.i.sd = sd; v.i.sl = sl; v.i.off = off;
    return v;
  endfunction

  function automatic vec_t bc(logic [3:0] l, logic [31:0] d, out_t e);
    vec_t v;
    v = nop(1'b0, e);
    v.i.bcen = 1'b1; v.i.bcl = l; v.i.bcd = d;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    out_t got;
    @(negedge clk);
    nRST = v.i.rst_n; WEN = v.i.wen; opIn = v.i.op;
    baseData = v.i.base; baseLabel = v.i.bl;
    storeData = v.i.sd; storeLabel = v.i.sl; offset = v.i.off;
    BCEN = v.i.bcen; BClabel = v.i.bcl; BCdata = v.i.bcd; requireAC = v.i.ac;
    @(posedge clk);
    #1;
    got = {isFull, writeable_labelOut, require, dataOut, labelOut};
    n_vec++;
    if (got !== v.o) begin
      n_mis++;
      $display("FAIL %s: got full=%b wl=%0d req=%b data=%h label=%0d, expected full=%b wl=%0d req=%b data=%h label=%0d",
               name, got.full, got.wl, got.req, got.d, got.l, v.o.full, v.o.wl, v.o.req, v.o.d, v.o.l);
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t t;

    nRST = 1'b0; WEN = 1'b0; opIn = 1'b0; BCEN = 1'b0; requireAC = 1'b0;
    baseData = '0; storeData = '0; offset = '0; BCdata = '0;
    baseLabel = '0; storeLabel = '0; BClabel = '0;

    // Reset, then store 0xDEADBEEF to word 5 and load it back (tag 13).
    tbl.push_back(rst(E(0, 12, 0, 0, 0)));
    tbl.push_back(nop(0, E(0, 12, 0, 0, 0)));
    tbl.push_back(iss(ST, 32'h10, 0, 32'hDEADBEEF, 0, 32'd4, E(0, 13, 0, 0, 0)));
    tbl.push_back(iss(LD, 32'h10, 0, 32'h0, 0, 32'd4, E(0, 14, 0, 0, 0)));
    repeat (4) tbl.push_back(nop(0, E(0, 14, 0, 0, 0)));
    tbl.push_back(nop(0, E(0, 14, 1, 32'hDEADBEEF, 13)));
    tbl.push_back(nop(0, E(0, 14, 1, 32'hDEADBEEF, 13)));
    tbl.push_back(nop(1, E(0, 14, 0, 0, 0)));

    // Store to word 2, then a load waiting on tag 3 resolved 5 cycles later.
    tbl.push_back(iss(ST, 32'h8, 0, 32'h12345678, 0, 32'd0, E(0, 15, 0, 0, 0)));
    tbl.push_back(iss(LD, 32'h0, 3, 32'h0, 0, 32'd0, E(0, 12, 0, 0, 0)));
    repeat (4) tbl.push_back(nop(0, E(0, 12, 0, 0, 0)));
    tbl.push_back(bc(4'd3, 32'h8, E(0, 12, 0, 0, 0)));
    repeat (2) tbl.push_back(nop(0, E(0, 12, 0, 0, 0)));
    repeat (4) tbl.push_back(nop(0, E(0, 12, 1, 32'h12345678, 15)));
    tbl.push_back(nop(1, E(0, 12, 0, 0, 0)));

    // Fill with four loads pending on tag 7; a fifth issue is dropped.
    tbl.push_back(iss(LD, 32'h0, 7, 32'h0, 0, 32'd4, E(0, 13, 0, 0, 0)));
    tbl.push_back(iss(LD, 32'h0, 7, 32'h0, 9, 32'hFFFFFFF8, E(0, 14, 0, 0, 0)));
    tbl.push_back(iss(LD, 32'h0, 7, 32'h0, 0, 32'd4, E(0, 15, 0, 0, 0)));
    tbl.push_back(iss(LD, 32'h0, 7, 32'h0, 0, 32'hFFFFFFF8, E(1, 12, 0, 0, 0)));
    tbl.push_back(iss(LD, 32'h40, 0, 32'h0, 0, 32'd0, E(1, 12, 0, 0, 0)));
    tbl.push_back(bc(4'd7, 32'h10, E(1, 12, 0, 0, 0)));
    repeat (2) tbl.push_back(nop(0, E(1, 12, 0, 0, 0)));
    tbl.push_back(nop(0, E(1, 12, 1, 32'hDEADBEEF, 12)));
    // Grant plus issue on a full queue; new entry reuses tag 12 and bypasses tag 5.
    t = iss(LD, 32'hFFFF, 5, 32'h0, 0, 32'hFFFFFFE8, E(1, 13, 0, 0, 0));
    t.i.ac = 1'b1; t.i.bcen = 1'b1; t.i.bcl = 4'd5; t.i.bcd = 32'h20;
    tbl.push_back(t);
    repeat (2) tbl.push_back(nop(0, E(1, 13, 0, 0, 0)));
    tbl.push_back(nop(0, E(1, 13, 1, 32'h12345678, 13)));
    tbl.push_back(nop(1, E(0, 13, 0, 0, 0)));
    repeat (2) tbl.push_back(nop(0, E(0, 13, 0, 0, 0)));
    tbl.push_back(nop(0, E(0, 13, 1, 32'hDEADBEEF, 14)));
    tbl.push_back(nop(1, E(0, 13, 0, 0, 0)));
    repeat (2) tbl.push_back(nop(0, E(0, 13, 0, 0, 0)));
    tbl.push_back(nop(0, E(0, 13, 1, 32'h12345678, 15)));
    tbl.push_back(nop(1, E(0, 13, 0, 0, 0)));
    repeat (2) tbl.push_back(nop(0, E(0, 13, 0, 0, 0)));
    tbl.push_back(nop(0, E(0, 13, 1, 32'h12345678, 12)));
    tbl.push_back(nop(1, E(0, 13, 0, 0, 0)));

    // Store waiting on its data tag 6 blocks the younger load of the same word.
    tbl.push_back(iss(ST, 32'h10, 0, 32'h55555555, 6, 32'hC, E(0, 14, 0, 0, 0)));
    tbl.push_back(iss(LD, 32'h1C, 0, 32'h0, 0, 32'd0, E(0, 15, 0, 0, 0)));
    tbl.push_back(nop(0, E(0, 15, 0, 0, 0)));
    tbl.push_back(bc(4'd6, 32'hCAFE0001, E(0, 15, 0, 0, 0)));
    repeat (5) tbl.push_back(nop(0, E(0, 15, 0, 0, 0)));
    tbl.push_back(nop(0, E(0, 15, 1, 32'hCAFE0001, 14)));
    tbl.push_back(nop(1, E(0, 15, 0, 0, 0)));

    foreach (tbl[k])
      apply(tbl[k], $sformatf("vec%0d", k));

    // Reset while a load is requesting and a younger op is queued.
    apply(iss(LD, 32'h10, 0, 32'h0, 0, 32'd4, E(0, 12, 0, 0, 0)), "req_abort_issue");
    apply(nop(0, E(0, 12, 0, 0, 0)), "req_abort_access");
    apply(nop(0, E(0, 12, 0, 0, 0)), "req_abort_count");
    apply(iss(LD, 32'h0, 3, 32'h0, 0, 32'd0, E(0, 13, 1, 32'hDEADBEEF, 15)), "req_abort_req");
    apply(rst(E(0, 12, 0, 0, 0)), "req_abort_reset");
    apply(nop(0, E(0, 12, 0, 0, 0)), "req_abort_after");

    // Reset on the edge a store would write; word 5 must keep 0xDEADBEEF.
    apply(iss(ST, 32'h10, 0, 32'h0BADF00D, 0, 32'd4, E(0, 13, 0, 0, 0)), "st_abort_issue");
    apply(nop(0, E(0, 13, 0, 0, 0)), "st_abort_access");
    apply(nop(0, E(0, 13, 0, 0, 0)), "st_abort_count");
    apply(rst(E(0, 12, 0, 0, 0)), "st_abort_reset");
    apply(iss(LD, 32'h10, 0, 32'h0, 0, 32'd4, E(0, 13, 0, 0, 0)), "st_abort_load");
    apply(nop(0, E(0, 13, 0, 0, 0)), "st_abort_access2");
    apply(nop(0, E(0, 13, 0, 0, 0)), "st_abort_count2");
    apply(nop(0, E(0, 13, 1, 32'hDEADBEEF, 12)), "st_abort_word");
    apply(nop(1, E(0, 13, 0, 0, 0)), "st_abort_grant");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
